pipe_hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the 5-stage pipelined processor: fetch, decode, ALU, memory, write-back. It tracks destination-register metadata for the EX, MEM and WB stages and drives the EX-stage operand bypass muxes. It raises a one-cycle load-use stall and flushes the pipeline on a taken jump. It replaces the ad-hoc per-stage `wb_buf*`/`reg2_buf*` chains at the top level and keeps saturating stall/flush counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB destination
// metadata, drives EX bypass muxes, load-use stall, jump flush and debug counters.
module pipe_hazard_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wb,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic              ex_jump_taken,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_dst,
    output logic              wb_we,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              use1;
        logic              use2;
        logic [REG_AW-1:0] dst;
        logic              wb;
        logic              mem_read;
    } stage_t;

    stage_t            ex_q;
    stage_t            mem_q;
    stage_t            wb_q;
    logic [DATA_W-1:0] ex_rdata1_q;
    logic [DATA_W-1:0] ex_rdata2_q;
    logic              lu;
    logic              mem_fwd_ok;

    // Load in EX whose result the instruction in decode needs next cycle.
    always_comb begin
        lu = 1'b0;
        if (id_valid && ex_q.valid && ex_q.mem_read && ex_q.wb) begin
            lu = (id_use1 && (id_src1 == ex_q.dst)) || (id_use2 && (id_src2 == ex_q.dst));
        end
    end

    assign flush     = ex_jump_taken & ex_q.valid;
    assign stall     = lu & ~flush;
    assign ex_valid  = ex_q.valid;
    assign mem_valid = mem_q.valid;
    assign wb_valid  = wb_q.valid;
    assign wb_dst    = wb_q.dst;
    assign wb_we     = wb_q.valid & wb_q.wb;

    // A load sitting in MEM has no data yet, so it is never a bypass source.
    assign mem_fwd_ok = mem_q.valid & mem_q.wb & ~mem_q.mem_read;

    // Bypass selection; MEM is the younger producer and wins over WB.
    always_comb begin
        fwd_sel1 = 2'd0;
        ex_op1   = ex_rdata1_q;
        fwd_sel2 = 2'd0;
        ex_op2   = ex_rdata2_q;
        if (ex_q.use1 && mem_fwd_ok && (mem_q.dst == ex_q.src1)) begin
            fwd_sel1 = 2'd1;
            ex_op1   = mem_result;
        end else if (ex_q.use1 && wb_we && (wb_q.dst == ex_q.src1)) begin
            fwd_sel1 = 2'd2;
            ex_op1   = wb_result;
        end
        if (ex_q.use2 && mem_fwd_ok && (mem_q.dst == ex_q.src2)) begin
            fwd_sel2 = 2'd1;
            ex_op2   = mem_result;
        end else if (ex_q.use2 && wb_we && (wb_q.dst == ex_q.src2)) begin
            fwd_sel2 = 2'd2;
            ex_op2   = wb_result;
        end
    end

    // Stage shift; EX/MEM/WB always advance, only the ID->EX entry can become a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rdata1_q <= '0;
            ex_rdata2_q <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (flush || stall || !id_valid) begin
                ex_q        <= '0;
                ex_rdata1_q <= '0;
                ex_rdata2_q <= '0;
            end else begin
                ex_q <= '{valid: 1'b1, src1: id_src1, src2: id_src2, use1: id_use1,
                          use2: id_use2, dst: id_dst, wb: id_wb, mem_read: id_mem_read};
                ex_rdata1_q <= id_rdata1;
                ex_rdata2_q <= id_rdata2;
            end
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Source fields of MEM/WB are kept for debug visibility but feed no logic.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{mem_q.src1, mem_q.src2, mem_q.use1, mem_q.use2,
                                 wb_q.src1, wb_q.src2, wb_q.use1, wb_q.use2, wb_q.mem_read};

endmodule
